write_buffer: RTL and testbench
===============================

Name: write_buffer

Overview:
- Posted write buffer sitting downstream of the cache controller and data array, and upstream of the 128-bit block memory.
- Store hits and misses (write-through) push {address, data} pairs into a FIFO, so the CPU does not stall on memory write latency.
- The buffer drains entries to memory one at a time over the mem_write/mem_ready handshake.
- It flags a read conflict whenever a block refill targets a block that still has pending writes.

Parameters:
- WIDTH, 32, address and data word width.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- BLK_OFF, 4, byte-offset bits inside a 128-bit block; block address is addr[WIDTH-1:BLK_OFF].

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- wb_push  input  1  enqueue request from the cache controller.
- wb_addr  input  WIDTH  write address.
- wb_wdata  input  WIDTH  write data.
- wb_full  output  1  push not accepted this cycle.
- wb_empty  output  1  no valid entries and no write in flight.
- rd_req  input  1  controller is about to issue a block refill.
- rd_addr  input  WIDTH  refill address.
- rd_conflict  output  1  a pending entry matches the rd_addr block.
- flush  input  1  one-cycle request to drain everything.
- flush_done  output  1  one-cycle pulse when the drain completes.
- mem_write  output  1  write request to memory.
- mem_addr  output  WIDTH  address of the head entry.
- mem_wdata  output  WIDTH  data of the head entry.
- mem_ready  input  1  memory accepted the write.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst=0:
  - FIFO pointers, count and all valid bits clear; FSM goes to IDLE.
  - mem_write=0, mem_addr=0, mem_wdata=0, wb_full=0, wb_empty=1, rd_conflict=0, flush_done=0.
  - Reset during a memory write aborts it: mem_write drops immediately and the entry is lost.
- Push:
  - Accepted on a rising edge when wb_push=1 and wb_full=0; the entry is written at wr_ptr and count increments.
  - wb_full = (count==DEPTH) or flush_pending; it is combinational from registered state.
  - A push while wb_full=1 is ignored, with no state change. The controller must hold the request and stall.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.
- Drain FSM:
  - IDLE: if count>0, load the head into the mem_addr/mem_wdata registers and go to WRITE on the next edge. A pushed entry therefore appears on mem_write at the earliest one cycle after the push edge.
  - WRITE:
    - mem_write=1, with mem_addr/mem_wdata held stable.
    - On an edge with mem_ready=1: pop the head (rd_ptr+1, count-1) and go to GAP.
    - While mem_ready=0: remain in WRITE indefinitely.
  - GAP: mem_write=0 for exactly one cycle, so the memory sees a fresh request; then go to IDLE.
  - Sustained throughput is therefore at most one write per 3 cycles plus memory latency.
- Read conflict:
  - rd_conflict = rd_req AND (any valid entry, including the in-flight head, has addr[WIDTH-1:BLK_OFF] == rd_addr[WIDTH-1:BLK_OFF]). It is combinational.
  - While rd_conflict=1 the controller must not assert mem_read. It clears as soon as the last matching entry is popped.
  - rd_req=0 forces rd_conflict=0.
- Flush:
  - A flush pulse sets flush_pending, which blocks pushes.
  - flush_done pulses for one cycle on the first edge where flush_pending=1, count==0 and state==IDLE; flush_pending clears on that same edge.
  - Flush with an already-empty buffer: flush_done appears on the edge after the flush pulse.
  - A flush while flush_pending is already set is ignored.
  - A flush in the same cycle as a push: the push is accepted, because wb_full is evaluated before flush_pending rises, and that entry is drained before flush_done.
- wb_empty = (count==0) and (state==IDLE).

Test Plan:
- Single write: push 0x0000_0010/0xDEAD_BEEF, mem_ready returns 3 cycles after mem_write rises -> mem_write high for 3 cycles with stable addr/data, one GAP cycle, then wb_empty=1.
- Fill and full:
  - With mem_ready tied 0, push 4 entries -> wb_full=1 after the 4th.
  - A 5th push is ignored.
  - Releasing mem_ready drains the entries in order A0..A3, and wb_full drops on the edge of the first pop.
- Wrap-around: push 4, drain 2, push 2 more -> drain order is exact and pointers wrap without loss or duplication over 3 full cycles of the FIFO.
- Read conflict:
  - Pending write to 0x0000_0024 with rd_req for 0x0000_0028 -> rd_conflict=1 (same block 0x2).
  - rd_req for 0x0000_0030 -> rd_conflict=0.
  - After the 0x24 entry is popped -> rd_conflict=0.
- Flush:
  - 3 pending entries plus a flush pulse -> wb_full=1 throughout and pushes ignored; flush_done pulses once after the third mem_ready.
  - Flush on an empty buffer -> flush_done on the next edge.
- Async reset: assert rst=0 mid-WRITE between clock edges -> mem_write=0 immediately, wb_empty=1; after release, a new push drains normally.

Source files
------------

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - posted write FIFO with in-order drain, block conflict detect and flush
module write_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int BLK_OFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_push,
  input  logic [WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_wdata,
  output logic             wb_full,
  output logic             wb_empty,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] rd_addr,
  output logic             rd_conflict,
  input  logic             flush,
  output logic             flush_done,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             flush_pending;
  logic             push_ok, pop, load_head, drain_done;
  logic             rd_off_unused;

  // Only the block part of the refill address takes part in the conflict compare.
  assign rd_off_unused = ^rd_addr[BLK_OFF-1:0];

  assign wb_full    = (count == FULL_CNT) || flush_pending;
  assign wb_empty   = (count == '0) && (state == IDLE);
  assign push_ok    = wb_push && !wb_full;
  assign drain_done = flush_pending && (count == '0) && (state == IDLE);

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= wb_addr;
      data_q[wr_ptr] <= wb_wdata;
    end
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Drain FSM: load head, hold the request until accepted, then one idle gap cycle.
  always_comb begin
    state_nxt = state;
    mem_write = 1'b0;
    load_head = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_head = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          pop       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Head entry is captured once so addr/data stay stable for the whole request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_head) begin
      mem_addr  <= addr_q[rd_ptr];
      mem_wdata <= data_q[rd_ptr];
    end
  end

  // Flush tracking: pending blocks pushes until everything has drained, then pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      flush_done <= drain_done;
      if (drain_done)  flush_pending <= 1'b0;
      else if (flush)  flush_pending <= 1'b1;
    end
  end

  // Refill conflict: any still-valid entry (including the one in flight) in the same block.
  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][WIDTH-1:BLK_OFF] == rd_addr[WIDTH-1:BLK_OFF]))
        rd_conflict = 1'b1;
    end
    if (!rd_req) rd_conflict = 1'b0;
  end

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - directed and randomized check of write_buffer against a queue model
module tb_write_buffer;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int BLK_OFF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_push;
  logic [WIDTH-1:0] wb_addr;
  logic [WIDTH-1:0] wb_wdata;
  logic             wb_full;
  logic             wb_empty;
  logic             rd_req;
  logic [WIDTH-1:0] rd_addr;
  logic             rd_conflict;
  logic             flush;
  logic             flush_done;
  logic             mem_write;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;

  always #5 clk = ~clk;

  write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BLK_OFF(BLK_OFF)) dut (
    .clk(clk), .rst(rst),
    .wb_push(wb_push), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_full(wb_full), .wb_empty(wb_empty),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_conflict(rd_conflict),
    .flush(flush), .flush_done(flush_done),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes in program order, plus a few protocol flags.
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] popped[$];
  logic [31:0] expect_order[$];
  bit          m_flush, m_gap, exp_fdone, exp_wr;
  int          fdone_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q_addr.delete();
    q_data.delete();
    m_flush   = 1'b0;
    m_gap     = 1'b0;
    exp_fdone = 1'b0;
    exp_wr    = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, then advance model and DUT together.
  task automatic tick();
    bit          fullp, hit, acc, pop, idle_pre;
    logic [31:0] ea, ed;
    #1;
    fullp = (q_addr.size() == DEPTH) || m_flush;
    hit   = 1'b0;
    foreach (q_addr[i])
      if ((q_addr[i] >> BLK_OFF) == (rd_addr >> BLK_OFF)) hit = 1'b1;
    chk("wb_full", wb_full, fullp);
    chk("rd_conflict", rd_conflict, rd_req && hit);
    chk("wb_empty", wb_empty, (q_addr.size() == 0) && !m_gap);
    chk("flush_done", flush_done, exp_fdone);
    if (flush_done) fdone_seen++;
    if (m_gap)  chk("gap_cycle", mem_write, 1'b0);
    if (exp_wr) chk("mem_write", mem_write, 1'b1);
    if (mem_write) begin
      ea = 'x;
      ed = 'x;
      if (q_addr.size() != 0) begin
        ea = q_addr[0];
        ed = q_data[0];
      end
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
    end
    acc       = wb_push && !fullp;
    pop       = mem_write && mem_ready;
    idle_pre  = !mem_write && !m_gap;
    exp_wr    = (idle_pre && q_addr.size() != 0) || (mem_write && !mem_ready);
    exp_fdone = m_flush && (q_addr.size() == 0) && idle_pre;
    if (pop && q_addr.size() != 0) begin
      popped.push_back(mem_addr);
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (acc) begin
      q_addr.push_back(wb_addr);
      q_data.push_back(wb_wdata);
    end
    if (exp_fdone)  m_flush = 1'b0;
    else if (flush) m_flush = 1'b1;
    m_gap = pop;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wb_push  = 1'b1;
    wb_addr  = a;
    wb_wdata = d;
    tick();
    wb_push  = 1'b0;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    for (int k = 0; k < 100 && (q_addr.size() != 0 || m_gap); k++) tick();
    mem_ready = 1'b0;
    #1;
    chk("drain_empty", wb_empty, 1'b1);
  endtask

  task automatic drain_n(input int n);
    int target;
    target    = popped.size() + n;
    mem_ready = 1'b1;
    for (int k = 0; k < 100 && popped.size() < target; k++) tick();
    mem_ready = 1'b0;
    chk("drain_n_count", popped.size(), target);
  endtask

  task automatic cmp_order(input string tag);
    chk({tag, "_len"}, popped.size(), expect_order.size());
    foreach (expect_order[i]) chk(tag, (i < popped.size()) ? popped[i] : 32'hxxxx_xxxx, expect_order[i]);
  endtask

  initial begin
    wb_push = 0; wb_addr = 0; wb_wdata = 0; rd_req = 0; rd_addr = 0;
    flush = 0; mem_ready = 0; rst = 0;
    reset_model();
    fdone_seen = 0;
    repeat (2) @(negedge clk);

    // Reset values
    rd_req = 1'b1;
    #1;
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_wb_full", wb_full, 1'b0);
    chk("rst_wb_empty", wb_empty, 1'b1);
    chk("rst_rd_conflict", rd_conflict, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single write, ready on the third request cycle
    push(32'h0000_0010, 32'hDEAD_BEEF);
    #1 chk("single_idle", mem_write, 1'b0);
    tick();
    chk("single_wr1", mem_write, 1'b1);
    chk("single_addr", mem_addr, 32'h0000_0010);
    chk("single_data", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("single_wr2", mem_write, 1'b1);
    tick();
    chk("single_wr3", mem_write, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("single_gap", mem_write, 1'b0);
    chk("single_gap_busy", wb_empty, 1'b0);
    tick();
    chk("single_empty", wb_empty, 1'b1);

    // Fill to full, ignored fifth push, in-order drain
    popped.delete();
    expect_order = '{32'h100, 32'h204, 32'h308, 32'h40C};
    foreach (expect_order[i]) push(expect_order[i], 32'hA000_0000 + i);
    #1 chk("full_after_4", wb_full, 1'b1);
    push(32'h500, 32'hBAD0_0005);
    chk("full_still", wb_full, 1'b1);
    mem_ready = 1'b1;
    tick();
    #1 chk("full_drop_on_pop", wb_full, 1'b0);
    drain();
    cmp_order("fill_order");

    // Wrap-around over three FIFO cycles
    popped.delete();
    expect_order.delete();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        expect_order.push_back(32'h1000 + 32'((r * 6 + j) * 16));
        push(expect_order[$], 32'hC000_0000 + 32'(r * 6 + j));
      end
      drain_n(2);
      for (int j = 4; j < 6; j++) begin
        expect_order.push_back(32'h1000 + 32'((r * 6 + j) * 16));
        push(expect_order[$], 32'hC000_0000 + 32'(r * 6 + j));
      end
      drain();
    end
    cmp_order("wrap_order");

    // Read conflict
    push(32'h0000_0024, 32'h1111_2222);
    push(32'h0000_0100, 32'h3333_4444);
    rd_req = 1'b1; rd_addr = 32'h0000_0028;
    #1 chk("conf_same_blk", rd_conflict, 1'b1);
    rd_addr = 32'h0000_0030;
    #1 chk("conf_other_blk", rd_conflict, 1'b0);
    rd_req = 1'b0; rd_addr = 32'h0000_002C;
    #1 chk("conf_no_req", rd_conflict, 1'b0);
    rd_req = 1'b1; rd_addr = 32'h0000_0028;
    drain_n(1);
    #1 chk("conf_after_pop", rd_conflict, 1'b0);
    chk("conf_still_pending", wb_empty, 1'b0);
    rd_addr = 32'h0000_0104;
    #1 chk("conf_second", rd_conflict, 1'b1);
    rd_req = 1'b0;
    drain();

    // Flush with three pending entries; pushes blocked throughout
    push(32'h600, 1); push(32'h610, 2); push(32'h620, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wb_push = 1'b1; wb_addr = 32'h900; wb_wdata = 32'h9;
    repeat (3) tick();
    #1 chk("flush_blocks", wb_full, 1'b1);
    wb_push = 1'b0;
    fdone_seen = 0;
    drain();
    repeat (3) tick();
    chk("flush_pulses", fdone_seen, 1);
    #1 chk("flush_unblock", wb_full, 1'b0);

    // Flush on an empty buffer
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    #1 chk("flush_empty_done", flush_done, 1'b1);
    tick();
    chk("flush_empty_once", flush_done, 1'b0);

    // Flush together with a push: entry is accepted and drained first
    fdone_seen = 0;
    popped.delete();
    flush = 1'b1;
    push(32'h700, 32'h7777);
    flush = 1'b0;
    drain();
    repeat (3) tick();
    chk("flush_push_drained", (popped.size() > 0) ? popped[0] : 32'h0, 32'h700);
    chk("flush_push_pulse", fdone_seen, 1);

    // Asynchronous reset in the middle of a write
    push(32'h40, 32'h4040);
    tick();
    #1 chk("ar_writing", mem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("ar_mem_write", mem_write, 1'b0);
    chk("ar_wb_empty", wb_empty, 1'b1);
    chk("ar_mem_addr", mem_addr, 32'h0);
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    popped.delete();
    push(32'h80, 32'h8080);
    drain();
    chk("ar_after", (popped.size() > 0) ? popped[0] : 32'h0, 32'h80);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      wb_push   = 1'($urandom_range(0, 1));
      wb_addr   = 32'($urandom_range(0, 63)) << 2;
      wb_wdata  = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      rd_req    = 1'($urandom_range(0, 1));
      rd_addr   = 32'($urandom_range(0, 63)) << 2;
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    wb_push = 1'b0; flush = 1'b0; rd_req = 1'b0;
    drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
